count_ones_stream: RTL and testbench
====================================

// Module: count_ones_stream
// PURPOSE
//   Parametrised, handshaked bit-counter. Accepts one WORD_SIZE operand per transaction
//   and counts ones (mode=0) or zeros (mode=1), BITS_PER_CYCLE bits per clock.
//   Terminates early once no counted bits remain. Holds the result until the consumer
//   takes it. Sits between a data producer and a downstream consumer; replaces the
//   fixed 4-bit, 1-bit/cycle counter.
// PARAMETERS
//   WORD_SIZE       16  operand width, >= 1
//   BITS_PER_CYCLE   4  bits consumed per SHIFT cycle, 1..WORD_SIZE
//   COUNT_W         (localparam) $clog2(WORD_SIZE+1); width of bit_count
// PORTS
//   clk         in   1          rising-edge clock
//   reset_n     in   1          asynchronous, active-low reset
//   data        in   WORD_SIZE  operand
//   mode        in   1          0 = count ones, 1 = count zeros; sampled at accept only
//   data_ready  in   1          producer valid
//   in_ready    out  1          block can accept; transfer when data_ready && in_ready
//   clear       in   1          synchronous abort
//   bit_count   out  COUNT_W    result, or running count while busy
//   start       out  1          high for exactly the first SHIFT cycle after accept
//   busy        out  1          high while in SHIFT
//   done        out  1          result valid; high throughout DONE
//   out_ready   in   1          consumer takes result when done && out_ready
// BEHAVIOUR
//   States: IDLE, SHIFT, DONE. reset_n low forces IDLE at once.
//   Reset values: temp=0, bit_count=0, start=0, busy=0, done=0, in_ready=1.
//   Operand load: op = mode ? ~data : data. Inversion is applied to WORD_SIZE bits only,
//     then op is zero-extended to a multiple of BITS_PER_CYCLE.
//   IDLE:  accept -> temp<=op, bit_count<=0 -> SHIFT.
//   SHIFT: each cycle, bit_count += popcount(temp[BITS_PER_CYCLE-1:0]),
//          then temp <= temp >> BITS_PER_CYCLE.
//          If the shifted temp == 0 -> DONE, else stay in SHIFT.
//   Latency: done rises N edges after the accept edge.
//     N = max(1, ceil((h+1)/BITS_PER_CYCLE)), where h is the index of the highest set
//     bit of op. A zero op gives N = 1 and count 0.
//   DONE:  bit_count stable while !out_ready.
//     - On out_ready with no new accept: clear done -> IDLE.
//     - in_ready = IDLE || (DONE && out_ready). A back-to-back accept in the same cycle
//       goes directly DONE -> SHIFT with bit_count<=0 and start=1.
//   in_ready is 0 in SHIFT. data_ready there is ignored, not queued.
//   clear (any state) -> IDLE next edge; temp, bit_count, done, busy, start all go to 0.
//     clear has priority over an accept in the same cycle; no transfer occurs.
//   reset_n asserted mid-SHIFT or in DONE: result discarded, all outputs at reset values.
//   bit_count never exceeds WORD_SIZE; no wrap.
// TESTING (WORD_SIZE=16, BITS_PER_CYCLE=4)
//   1 Reset: reset_n low with data_ready=1 -> in_ready=1, done=0, busy=0, bit_count=0.
//     No accept occurs until reset_n is released.
//   2 data=16'h00F1, mode=0 -> start 1 cycle, busy 2 cycles, done after 2 edges,
//     bit_count=5.
//   3 data=16'hFFFF: mode=0 -> N=4, count 16; mode=1 -> N=1, count 0.
//     data=16'h0000, mode=1 -> N=4, count 16.
//   4 data=16'h8001, mode=0 -> done after 4 edges, count 2. Hold out_ready=0 for
//     5 cycles -> done and count=2 stable; data_ready pulses ignored.
//   5 Back-to-back with out_ready=1: 16'h0003 then 16'h0100 -> in_ready high in DONE,
//     2nd accepted same cycle, results 2 then 1, no idle gap.
//   6 clear one cycle after accept of 16'hFFFF -> IDLE next edge, count 0, no done.
//     Repeat with async reset_n pulse mid-SHIFT -> same result.

Source files
------------

// File: rtl/count_ones_stream_if.sv
// Producer/consumer handshake bundle for count_ones_stream: operand in, count result out.
// master = the producer/consumer side, slave = the counter.
interface count_ones_stream_if #(
  parameter int WORD_SIZE = 16
);
  localparam int COUNT_W = $clog2(WORD_SIZE + 1);

  logic [WORD_SIZE-1:0] data;
  logic                 mode;
  logic                 data_ready;
  logic                 in_ready;
  logic                 clear;
  logic [COUNT_W-1:0]   bit_count;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 out_ready;

  modport master (
    output data, mode, data_ready, clear, out_ready,
    input  in_ready, bit_count, start, busy, done
  );

  modport slave (
    input  data, mode, data_ready, clear, out_ready,
    output in_ready, bit_count, start, busy, done
  );
endinterface

// File: rtl/count_ones_stream.sv
// Counts ones/zeros of one operand, BITS_PER_CYCLE bits per clock; done N edges after accept, N per highest counted bit.
// in_ready only in IDLE or when the held result is being taken; result held in DONE until out_ready.
module count_ones_stream #(
  parameter int WORD_SIZE      = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input logic               clk,
  input logic               reset_n,
  count_ones_stream_if.slave bus
);
  localparam int COUNT_W = $clog2(WORD_SIZE + 1);
  localparam int NSLICE  = (WORD_SIZE + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int PAD_W   = NSLICE * BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [PAD_W-1:0]   temp;
  logic [PAD_W-1:0]   op;
  logic [PAD_W-1:0]   temp_next;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] slice_ones;
  logic               start_q;
  logic               busy_q;
  logic               done_q;
  logic               in_ready;
  logic               accept;

  // Inversion covers only the real operand bits; the padding stays zero so it is never counted.
  always_comb begin
    op                  = '0;
    op[WORD_SIZE-1:0]   = bus.mode ? ~bus.data : bus.data;
  end

  assign temp_next = temp >> BITS_PER_CYCLE;

  always_comb begin
    slice_ones = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_ones = slice_ones + COUNT_W'(temp[i]);
    end
  end

  // A clear cycle never shows in_ready, so the producer never sees a transfer that was dropped.
  assign in_ready = !bus.clear && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
  assign accept   = bus.data_ready && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      temp    <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.clear) begin
      state   <= S_IDLE;
      temp    <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            temp    <= op;
            count_q <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          count_q <= count_q + slice_ones;
          temp    <= temp_next;
          if (temp_next == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            done_q <= 1'b0;
            if (accept) begin
              temp    <= op;
              count_q <= '0;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state   <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.bit_count = count_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_count_ones_stream.sv
// Bench for count_ones_stream (16-bit operand, 4 bits/cycle): transaction-level model checked
// every cycle, plus directed transactions with hand-computed latency and count.
module tb_count_ones_stream;
  localparam int WS  = 16;
  localparam int BPC = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  always #5 clk = ~clk;

  count_ones_stream_if #(.WORD_SIZE(WS)) bus ();

  count_ones_stream #(.WORD_SIZE(WS), .BITS_PER_CYCLE(BPC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int ones_below(input logic [WS-1:0] v, input int nbits);
    int c = 0;
    for (int i = 0; i < WS; i++) if (i < nbits && v[i]) c++;
    return c;
  endfunction

  function automatic int slices_needed(input logic [WS-1:0] v);
    int h = -1;
    for (int i = 0; i < WS; i++) if (v[i]) h = i;
    if (h < 0) return 1;
    return (h + BPC) / BPC;
  endfunction

  // One outstanding transaction: operand, edges elapsed since accept, edges it needs.
  logic          m_active;
  logic [WS-1:0] m_op;
  int            m_k;
  int            m_n;
  int            m_last;
  logic          m_acc;

  function automatic logic m_in_ready();
    return !bus.clear && (!m_active || (m_k >= m_n && bus.out_ready));
  endfunction

  function automatic int m_count();
    if (!m_active) return m_last;
    return ones_below(m_op, m_k * BPC);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_n      = 1;
      m_last   = 0;
    end else if (bus.clear) begin
      m_active = 1'b0;
      m_last   = 0;
    end else begin
      m_acc = bus.data_ready && m_in_ready();
      if (m_active && m_k >= m_n && bus.out_ready) begin
        m_last   = m_count();
        m_active = 1'b0;
      end else if (m_active && m_k < m_n) begin
        m_k++;
      end
      if (m_acc) begin
        m_active = 1'b1;
        m_op     = bus.mode ? ~bus.data : bus.data;
        m_k      = 0;
        m_n      = slices_needed(m_op);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", int'(bus.in_ready), int'(m_in_ready()));
      chk("cyc_busy", int'(bus.busy), int'(m_active && m_k < m_n));
      chk("cyc_start", int'(bus.start), int'(m_active && m_k == 0));
      chk("cyc_done", int'(bus.done), int'(m_active && m_k >= m_n));
      chk("cyc_count", int'(bus.bit_count), m_count());
    end
  end

  // ---------------- directed stimulus ----------------
  // Entered and left at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic wait_accept(input string name);
    int t = 0;
    #1;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_accept_seen"}, int'(bus.in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [WS-1:0] d, input logic m, input int exp_n,
                         input int exp_cnt, input string name);
    int e = 0;
    int nb = 0;
    int ns = 0;
    bus.data       = d;
    bus.mode       = m;
    bus.data_ready = 1'b1;
    bus.out_ready  = 1'b0;
    wait_accept(name);
    bus.data_ready = 1'b0;
    nb += int'(bus.busy);
    ns += int'(bus.start);
    while (!bus.done && e < 20) begin
      @(posedge clk); #1;
      e++;
      nb += int'(bus.busy);
      ns += int'(bus.start);
    end
    chk({name, "_latency"}, e, exp_n);
    chk({name, "_count"}, int'(bus.bit_count), exp_cnt);
    chk({name, "_busy_cycles"}, nb, exp_n);
    chk({name, "_start_cycles"}, ns, 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset_n        = 1'b0;
    bus.data       = 16'hFFFF;
    bus.mode       = 1'b0;
    bus.data_ready = 1'b1;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b0;

    // model pinned against hand-computed values
    chk("model_n_00F1", slices_needed(16'h00F1), 2);
    chk("model_n_8001", slices_needed(16'h8001), 4);
    chk("model_n_0000", slices_needed(16'h0000), 1);
    chk("model_n_0100", slices_needed(16'h0100), 3);
    chk("model_ones_00F1", ones_below(16'h00F1, 16), 5);

    // reset held with data_ready high: nothing accepted
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_count", int'(bus.bit_count), 0);
    end
    bus.data_ready = 1'b0;
    reset_n        = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", int'(bus.busy), 0);

    run_txn(16'h00F1, 1'b0, 2, 5, "t00F1");
    take();
    chk("after_take_done", int'(bus.done), 0);
    chk("after_take_count_held", int'(bus.bit_count), 5);

    run_txn(16'hFFFF, 1'b0, 4, 16, "tFFFF_ones");
    take();
    run_txn(16'hFFFF, 1'b1, 1, 0, "tFFFF_zeros");
    take();
    run_txn(16'h0000, 1'b1, 4, 16, "t0000_zeros");
    take();

    // result held while consumer stalls; producer pulses ignored
    run_txn(16'h8001, 1'b0, 4, 2, "t8001");
    bus.data = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      bus.data_ready = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_done", int'(bus.done), 1);
      chk("hold_count", int'(bus.bit_count), 2);
      chk("hold_busy", int'(bus.busy), 0);
    end
    bus.data_ready = 1'b0;
    take();

    // back-to-back: second operand accepted in the DONE cycle
    bus.out_ready  = 1'b1;
    bus.data       = 16'h0003;
    bus.mode       = 1'b0;
    bus.data_ready = 1'b1;
    wait_accept("b2b_first");
    bus.data = 16'h0100;
    chk("b2b_first_start", int'(bus.start), 1);
    @(posedge clk); #1;
    chk("b2b_first_done", int'(bus.done), 1);
    chk("b2b_first_count", int'(bus.bit_count), 2);
    chk("b2b_in_ready_in_done", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    chk("b2b_second_start", int'(bus.start), 1);
    chk("b2b_second_busy", int'(bus.busy), 1);
    chk("b2b_second_count0", int'(bus.bit_count), 0);
    e = 0;
    while (!bus.done && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    chk("b2b_second_latency", e, 3);
    chk("b2b_second_count", int'(bus.bit_count), 1);
    bus.out_ready = 1'b0;
    take();

    // clear beats a same-cycle accept
    bus.data       = 16'h00FF;
    bus.data_ready = 1'b1;
    bus.clear      = 1'b1;
    #1;
    chk("clr_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.clear      = 1'b0;
    bus.data_ready = 1'b0;
    chk("clr_no_accept", int'(bus.busy), 0);
    chk("clr_count", int'(bus.bit_count), 0);

    // clear one cycle into SHIFT
    bus.data       = 16'hFFFF;
    bus.data_ready = 1'b1;
    wait_accept("clr_mid");
    bus.data_ready = 1'b0;
    bus.clear      = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    chk("clr_mid_busy", int'(bus.busy), 0);
    chk("clr_mid_done", int'(bus.done), 0);
    chk("clr_mid_count", int'(bus.bit_count), 0);
    e = 0;
    repeat (6) begin
      @(posedge clk); #1;
      e += int'(bus.done);
    end
    chk("clr_mid_no_done", e, 0);

    // async reset pulse mid-SHIFT
    bus.data_ready = 1'b1;
    wait_accept("rst_mid");
    bus.data_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    chk("rst_mid_count", int'(bus.bit_count), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    #2;
    reset_n = 1'b1;
    e = 0;
    repeat (6) begin
      @(posedge clk); #1;
      e += int'(bus.done);
    end
    chk("rst_mid_no_done", e, 0);

    run_txn(16'h1234, 1'b1, 4, 11, "t1234_zeros");
    take();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
